// File: rtl/mux4_arb_pkg.sv
// Shared types and constants for the 4-requester round-robin mux arbiter.
package mux4_arb_pkg;

  localparam int NREQ  = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic logic [NREQ-1:0] onehot4(input logic [SEL_W-1:0] idx);
    logic [NREQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational rotating-priority picker: first set req at or after ptr (mod 4).
module rr_pick4
  import mux4_arb_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] cand;

  // Walk from lowest to highest priority so the last hit (closest to ptr) wins.
  always_comb begin
    any  = 1'b0;
    idx  = ptr;
    cand = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = ptr + SEL_W'(i);
      if (req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter owning the select of a 4:1 data mux, with bounded grant bursts.
// Handshake: req is a level; a requester owns the mux while gnt[k]=1, valid marks dout as live.
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int  DATA_W   = 1,
  parameter int  MAX_HOLD = 8,
  localparam int HOLD_W   = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DATA_W-1:0]   din,
  output logic [NREQ-1:0]          gnt,
  output logic [SEL_W-1:0]         sel,
  output logic                     valid,
  output logic [DATA_W-1:0]        dout,
  output state_t                   dbg_state,
  output logic [SEL_W-1:0]         dbg_ptr,
  output logic [HOLD_W-1:0]        dbg_hold_cnt
);

  state_t            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              rel;
  logic              pick_any;
  logic [SEL_W-1:0]  pick_idx;

  // ptr_q already equals owner+1 during GRANT, so one picker serves both
  // the idle arbitration and the zero-bubble release re-arbitration.
  rr_pick4 u_pick (
    .req (req),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    rel     = (state_q == GRANT) &&
              (!req[sel_q] || (hold_q == HOLD_W'(MAX_HOLD - 1)));
    if (state_q == IDLE || rel) begin
      if (pick_any) begin
        state_d = GRANT;
        sel_d   = pick_idx;
        gnt_d   = onehot4(pick_idx);
        hold_d  = '0;
        ptr_d   = pick_idx + SEL_W'(1);
      end else begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    end else begin
      hold_d = hold_q + HOLD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  assign gnt          = gnt_q;
  assign sel          = sel_q;
  assign valid        = (state_q == GRANT);
  assign dout         = valid ? din[int'(sel_q)*DATA_W +: DATA_W] : '0;
  assign dbg_state    = state_q;
  assign dbg_ptr      = ptr_q;
  assign dbg_hold_cnt = hold_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: hand-derived vector table, then random traffic checked against a reference model.
module tb_mux4_rr_arbiter;
  import mux4_arb_pkg::*;

  localparam int DATA_W   = 1;
  localparam int MAX_HOLD = 8;
  localparam int HOLD_W   = 3;
  localparam int EXP_W    = 14;

  logic              clk;
  logic              rst;
  logic [3:0]        req;
  logic [3:0]        din;
  logic [3:0]        gnt;
  logic [1:0]        sel;
  logic              valid;
  logic [0:0]        dout;
  state_t            dbg_state;
  logic [1:0]        dbg_ptr;
  logic [HOLD_W-1:0] dbg_hold_cnt;

  mux4_rr_arbiter #(.DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .din          (din),
    .gnt          (gnt),
    .sel          (sel),
    .valid        (valid),
    .dout         (dout),
    .dbg_state    (dbg_state),
    .dbg_ptr      (dbg_ptr),
    .dbg_hold_cnt (dbg_hold_cnt)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    rst = 1'b1;
    req = '0;
    din = '0;
  end
  always #5 clk = ~clk;

  // ---------------- vector table ----------------
  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] din;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
    logic       dout;
    string      tag;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic r, input logic [3:0] rq, input logic [3:0] d,
                         input logic [3:0] g, input logic [1:0] s, input logic v,
                         input logic o, input string tag);
    vec_t x;
    x.rst = r; x.req = rq; x.din = d; x.gnt = g; x.sel = s; x.valid = v; x.dout = o; x.tag = tag;
    vecs.push_back(x);
  endtask

  // ---------------- reference model ----------------
  bit         m_state;
  logic [1:0] m_owner;
  int         m_cnt;
  logic [1:0] m_ptr;

  task automatic model_step(input logic r, input logic [3:0] rq);
    bit need_pick;
    bit found;
    logic [1:0] w;
    if (r) begin
      m_state = 0; m_owner = 0; m_cnt = 0; m_ptr = 0;
      return;
    end
    need_pick = !m_state || !rq[m_owner] || (m_cnt == MAX_HOLD - 1);
    if (!need_pick) begin
      m_cnt++;
    end else begin
      found = 0;
      for (int j = 0; j < 4; j++) begin
        w = m_ptr + 2'(j);
        if (!found && rq[w]) begin
          found = 1; m_owner = w; m_cnt = 0; m_ptr = w + 2'd1;
        end
      end
      if (!found) m_state = 0;
      else        m_state = 1;
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [EXP_W-1:0] exp_q[$];
  string            tag_q[$];
  int               n_checks = 0;
  int               n_err    = 0;
  logic [EXP_W-1:0] e_cur;
  logic [EXP_W-1:0] a_cur;
  string            t_cur;

  // Driver: apply one cycle of stimulus away from the edge and queue the expectation.
  task automatic drive(input logic r, input logic [3:0] rq, input logic [3:0] d,
                       input bit use_tbl, input vec_t tv, input string tag);
    logic [3:0] g;
    logic [1:0] s;
    logic       v;
    logic       o;
    @(negedge clk);
    rst = r; req = rq; din = d;
    model_step(r, rq);
    v = m_state;
    s = m_owner;
    g = m_state ? (4'b0001 << m_owner) : 4'b0000;
    o = m_state ? d[m_owner] : 1'b0;
    if (use_tbl) begin
      g = tv.gnt; s = tv.sel; v = tv.valid; o = tv.dout;
    end
    exp_q.push_back({g, s, v, o, m_ptr, HOLD_W'(m_cnt), m_state});
    tag_q.push_back(tag);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      e_cur = exp_q.pop_front();
      t_cur = tag_q.pop_front();
      a_cur = {gnt, sel, valid, dout, dbg_ptr, dbg_hold_cnt, (dbg_state == GRANT)};
      n_checks++;
      if (a_cur !== e_cur) begin
        n_err++;
        $display("FAIL %s @%0t: got gnt=%b sel=%0d valid=%b dout=%b ptr=%0d hold=%0d st=%b, need gnt=%b sel=%0d valid=%b dout=%b ptr=%0d hold=%0d st=%b",
                 t_cur, $time, a_cur[13:10], a_cur[9:8], a_cur[7], a_cur[6], a_cur[5:4], a_cur[3:1], a_cur[0],
                 e_cur[13:10], e_cur[9:8], e_cur[7], e_cur[6], e_cur[5:4], e_cur[3:1], e_cur[0]);
      end
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    vec_t       none;
    logic [3:0] rq;
    logic [3:0] d;
    logic       r;

    none.rst = 0; none.req = 0; none.din = 0; none.gnt = 0; none.sel = 0;
    none.valid = 0; none.dout = 0; none.tag = "";

    // Reset with all requesting, then steady 1111: owners 0,1,2,3,0 for 8 cycles each.
    add_vec(1, 4'b1111, 4'b1111, 4'b0000, 2'd0, 0, 0, "reset");
    add_vec(1, 4'b1111, 4'b1111, 4'b0000, 2'd0, 0, 0, "reset");
    for (int k = 0; k < 40; k++) begin
      int o;
      o = (k / 8) % 4;
      add_vec(0, 4'b1111, 4'b1010, 4'(1 << o), 2'(o), 1, ((o % 2) == 1), "fairness");
    end
    // Sole requester across hold expiry keeps its grant without a gap.
    add_vec(1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, 0, "reset");
    for (int k = 0; k < 20; k++)
      add_vec(0, 4'b0001, 4'b0001, 4'b0001, 2'd0, 1, 1, "sole_hold");
    add_vec(0, 4'b0000, 4'b0001, 4'b0000, 2'd0, 0, 0, "sole_drop");
    // Single requester 2: grant, then drop; sel keeps last owner while idle.
    add_vec(0, 4'b0100, 4'b0100, 4'b0100, 2'd2, 1, 1, "single");
    add_vec(0, 4'b0100, 4'b0100, 4'b0100, 2'd2, 1, 1, "single");
    add_vec(0, 4'b0000, 4'b0100, 4'b0000, 2'd2, 0, 0, "single_drop");
    // Owner 1 drops with 1001 pending: ptr=2 so 3 wins over 0, no bubble.
    add_vec(1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, 0, "reset");
    add_vec(0, 4'b0010, 4'b1010, 4'b0010, 2'd1, 1, 1, "rotate");
    add_vec(0, 4'b1011, 4'b1010, 4'b0010, 2'd1, 1, 1, "rotate");
    add_vec(0, 4'b1001, 4'b1000, 4'b1000, 2'd3, 1, 1, "rotate_handoff");
    add_vec(0, 4'b1001, 4'b0000, 4'b1000, 2'd3, 1, 0, "rotate_hold");
    // Mid-burst reset on requester 2's 4th cycle; next grant starts from ptr=0.
    add_vec(1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, 0, "reset");
    for (int k = 0; k < 3; k++)
      add_vec(0, 4'b0100, 4'b0100, 4'b0100, 2'd2, 1, 1, "burst2");
    add_vec(1, 4'b0100, 4'b0100, 4'b0000, 2'd0, 0, 0, "midburst_rst");
    add_vec(0, 4'b1111, 4'b0001, 4'b0001, 2'd0, 1, 1, "post_rst_grant");

    foreach (vecs[i])
      drive(vecs[i].rst, vecs[i].req, vecs[i].din, 1, vecs[i], vecs[i].tag);

    // Random traffic checked by the reference model.
    drive(1, 4'b0000, 4'b0000, 0, none, "rand_reset");
    rq = 4'b0000;
    for (int k = 0; k < 400; k++) begin
      r = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 3) == 0) rq = 4'($urandom_range(0, 15));
      d = 4'($urandom_range(0, 15));
      drive(r, rq, d, 0, none, "random");
    end

    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expectations, need 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter that shares one 4:1 select datapath between four requesters. It grants one requester at a time and drives the 2-bit select to the mux. It then forwards the selected requester's data with a valid flag. Grants are held for a bounded burst so no requester starves. The block sits directly in front of the 4:1 mux datapath and is its only source of select.

## Interface
- DATA_W, 1, width of each requester's data lane
- MAX_HOLD, 8, max consecutive cycles one grant is held (≥1)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req  in  4  request per requester; req[k] belongs to requester k
- din  in  4*DATA_W  lane k at din[k*DATA_W +: DATA_W]
- gnt  out  4  one-hot registered grant; all-zero when idle
- sel  out  2  registered binary index of current owner (mux select)
- valid  out  1  high while a grant is active
- dout  out  DATA_W  din lane selected by sel when valid, else all-zero

## Operation
- States: IDLE (no owner), GRANT (owner = sel).
- Rotating pointer ptr[1:0]: highest priority goes to ptr, then ptr+1, ptr+2, ptr+3 (mod 4).
- IDLE, any req high: next state GRANT; owner = first requester with req high at or after ptr; hold_cnt←0; ptr←owner+1.
- IDLE, req==0: stay IDLE.
- GRANT, req[owner] high and hold_cnt<MAX_HOLD-1: keep owner, hold_cnt+1.
- GRANT, req[owner] low, or hold_cnt==MAX_HOLD-1: release. Re-arbitrate in the same cycle, with no bubble, using the updated ptr (owner+1). The winner may be the old owner only if it is the sole requester. This case also yields a fresh grant. If no req is high, go to IDLE.
- Every new grant, including a re-grant, clears hold_cnt and sets ptr←winner+1.
- hold_cnt width: $clog2(MAX_HOLD) with a minimum of 1. When MAX_HOLD=1, every GRANT cycle is a release point.
- dout = valid ? din[sel] : 0. This is combinational from registered sel/valid and live din.
- Invariants: gnt is one-hot or zero; gnt[sel]==valid; valid==(state==GRANT).

## Timing
- Reset values: state=IDLE, gnt=4'b0000, sel=2'b00, valid=0, dout=0, ptr=0, hold_cnt=0.
- Request-to-grant latency: 1 cycle. A req sampled high at edge N with the block idle gives gnt/valid high after edge N.
- Owner handoff: 0 idle cycles when another req is pending at the release edge.
- Dropping req[owner] at edge N ends the grant after edge N. The owner gets exactly one extra cycle of ownership after its last high req sample.
- Maximum continuous ownership: MAX_HOLD cycles. Maximum wait for any requester holding req high: 3*MAX_HOLD cycles after it is first sampled.
- rst high on any edge, including mid-burst, forces all reset values on that edge. req is ignored that cycle.
- Requests are level-sensitive. No handshake beyond req/gnt; requesters must keep req high until granted.

## Structure
- Shared package mux4_arb_pkg holds:
  - state typedef (IDLE, GRANT)
  - localparam NREQ=4, SEL_W=2
- One combinational sub-module, rr_pick4, takes inputs (req[3:0], ptr[1:0]) and returns outputs (any, idx[1:0]). It is also reused for the release-cycle re-arbitration.
- The data path is a plain indexed select on din. No other sub-modules.

## Test plan
- Reset: hold rst 2 cycles with req=4'b1111 -> gnt=0, sel=0, valid=0, dout=0. After release, the first grant is requester 0 (gnt=0001) one cycle later.
- Single requester: req=4'b0100, din lane2=1, others 0 -> one cycle later gnt=0100, sel=2, dout=1. Drop req -> valid=0 one cycle after the drop sample.
- Round-robin fairness: req=4'b1111 steady, MAX_HOLD=8 -> owners cycle 0,1,2,3,0, 8 cycles each with no idle gaps.
- Hold expiry, sole requester: req=4'b0001 steady for 20 cycles -> gnt stays 0001 continuously; hold_cnt restarts every 8 cycles.
- Priority rotation after release: owner 1 drops req while req=4'b1001 -> next owner is 3 (ptr=2), not 0, with zero bubble.
- Mid-burst reset: rst asserted at cycle 4 of requester 2's burst -> all outputs zero the next cycle. The next grant uses ptr=0.
